// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
//
// Drives a word-addressed, combinationally read instruction memory. It owns
// the program counter and registers each fetched word into a one-entry
// output stage. Decode drains that stage through a valid/ready handshake.
// Taken-branch redirects, downstream backpressure and end-of-program halt
// are handled here.
//
// Parameters:
//   N        instruction / address width
//   M        instruction memory depth in words (legal pc 0..M-1)
//   START_PC pc loaded on reset and on start
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   start        one-cycle pulse, starts fetching from START_PC (IDLE/DONE)
//   imem_addr    word address to instruction memory (always equals pc)
//   imem_instr   combinational read data for imem_addr
//   out_valid    output stage holds a valid instruction
//   out_ready    decode accepts when out_valid && out_ready
//   out_instr    registered instruction
//   out_pc       word address of out_instr
//   redirect     taken branch from execute, highest priority
//   redirect_pc  branch target word address
//   busy         high in FETCH and STALL
//   done         high in DONE
//   fetch_count  (FETCH_PERF_EN only) output-stage loads, saturating
//   stall_count  (FETCH_PERF_EN only) cycles spent in STALL, saturating
//
// Optional feature macro: FETCH_PERF_EN adds the two performance counters.
// ---------------------------------------------------------------------------
module fetch_sequencer #(
  parameter int          N        = 32,
  parameter int          M        = 256,
  parameter int unsigned START_PC = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic [N-1:0] imem_addr,
  input  logic [N-1:0] imem_instr,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_instr,
  output logic [N-1:0] out_pc,
  input  logic         redirect,
  input  logic [N-1:0] redirect_pc,
  output logic         busy,
`ifdef FETCH_PERF_EN
  output logic [N-1:0] fetch_count,
  output logic [N-1:0] stall_count,
`endif
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    STALL = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [N-1:0] START_PC_N = N'(START_PC);
  localparam logic [N-1:0] LAST_PC    = N'(M - 1);
  // One extra bit so the depth itself is representable for the range check.
  localparam logic [N:0]   DEPTH_EXT  = (N + 1)'(M);

  state_t       state_r;
  logic [N-1:0] pc_r;

  logic         stage_free_s;
  logic         last_word_s;
  logic         redirect_oob_s;
  logic         redirect_hit_s;
  logic [N-1:0] pc_inc_s;

  assign imem_addr = pc_r;

  // Decode the per-cycle fetch conditions from current state and inputs.
  always_comb begin
    stage_free_s   = 1'b0;
    last_word_s    = 1'b0;
    redirect_oob_s = 1'b0;
    redirect_hit_s = 1'b0;
    pc_inc_s       = pc_r + {{(N-1){1'b0}}, 1'b1};
    if (!out_valid || out_ready) begin
      stage_free_s = 1'b1;
    end else begin
      stage_free_s = 1'b0;
    end
    // The word being loaded ends the program if it sits at the top of memory
    // or is the all-zero terminator; either way the pc must not advance.
    if ((pc_r == LAST_PC) || (imem_instr == {N{1'b0}})) begin
      last_word_s = 1'b1;
    end else begin
      last_word_s = 1'b0;
    end
    if ({1'b0, redirect_pc} >= DEPTH_EXT) begin
      redirect_oob_s = 1'b1;
    end else begin
      redirect_oob_s = 1'b0;
    end
    // Redirect is ignored while IDLE, otherwise it beats every other event.
    if (redirect && (state_r != IDLE)) begin
      redirect_hit_s = 1'b1;
    end else begin
      redirect_hit_s = 1'b0;
    end
  end

  // Fetch FSM with registered output stage and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      pc_r      <= START_PC_N;
      out_valid <= 1'b0;
      out_instr <= {N{1'b0}};
      out_pc    <= {N{1'b0}};
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (redirect_hit_s) begin
      // Flush the stage now; the target is addressed next cycle and shows
      // up on the output one cycle after that.
      out_valid <= 1'b0;
      if (redirect_oob_s) begin
        state_r <= DONE;
        busy    <= 1'b0;
        done    <= 1'b1;
      end else begin
        pc_r    <= redirect_pc;
        state_r <= FETCH;
        busy    <= 1'b1;
        done    <= 1'b0;
      end
    end else begin
      case (state_r)
        IDLE: begin
          out_valid <= 1'b0;
          if (start) begin
            pc_r    <= START_PC_N;
            state_r <= FETCH;
            busy    <= 1'b1;
            done    <= 1'b0;
          end
        end
        FETCH, STALL: begin
          if (stage_free_s) begin
            // Accept of the held word and load of the next one share a cycle.
            out_instr <= imem_instr;
            out_pc    <= pc_r;
            out_valid <= 1'b1;
            if (last_word_s) begin
              state_r <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              pc_r    <= pc_inc_s;
              state_r <= FETCH;
            end
          end else begin
            state_r <= STALL;
          end
        end
        DONE: begin
          if (start) begin
            pc_r      <= START_PC_N;
            out_valid <= 1'b0;
            state_r   <= FETCH;
            busy      <= 1'b1;
            done      <= 1'b0;
          end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: begin
          state_r   <= IDLE;
          pc_r      <= START_PC_N;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic load_s;
  logic start_take_s;

  // Identify output-stage loads and accepted start pulses for the counters.
  always_comb begin
    load_s       = 1'b0;
    start_take_s = 1'b0;
    if (((state_r == FETCH) || (state_r == STALL)) && !redirect && stage_free_s) begin
      load_s = 1'b1;
    end else begin
      load_s = 1'b0;
    end
    if (start && ((state_r == IDLE) || ((state_r == DONE) && !redirect))) begin
      start_take_s = 1'b1;
    end else begin
      start_take_s = 1'b0;
    end
  end

  // Saturating load and stall counters, cleared by an accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count <= {N{1'b0}};
      stall_count <= {N{1'b0}};
    end else if (start_take_s) begin
      fetch_count <= {N{1'b0}};
      stall_count <= {N{1'b0}};
    end else begin
      if (load_s && (fetch_count != {N{1'b1}})) begin
        fetch_count <= fetch_count + {{(N-1){1'b0}}, 1'b1};
      end
      if ((state_r == STALL) && (stall_count != {N{1'b1}})) begin
        stall_count <= stall_count + {{(N-1){1'b0}}, 1'b1};
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic clk;
  logic rst;

  // DUT 0: default depth 256
  logic        start0, out_ready0, redirect0;
  logic [31:0] redirect_pc0, imem_addr0, imem_instr0, out_instr0, out_pc0;
  logic        out_valid0, busy0, done0;
  // DUT 1: depth 4
  logic        start1, out_ready1, redirect1;
  logic [31:0] redirect_pc1, imem_addr1, imem_instr1, out_instr1, out_pc1;
  logic        out_valid1, busy1, done1;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count0, stall_count0, fetch_count1, stall_count1;
`endif

  logic [31:0] mem0 [0:255];
  logic [31:0] mem1 [0:3];
  logic [31:0] max_addr1;

  exp_t sbq[$];
  int   ncomp = 0;
  int   nfail = 0;
  int   cyc = 0;
  int   first_acc = -1;
  int   last_acc = -1;

  fetch_sequencer #(.N(32), .M(256), .START_PC(0)) u0 (
    .clk(clk), .rst(rst), .start(start0),
    .imem_addr(imem_addr0), .imem_instr(imem_instr0),
    .out_valid(out_valid0), .out_ready(out_ready0),
    .out_instr(out_instr0), .out_pc(out_pc0),
    .redirect(redirect0), .redirect_pc(redirect_pc0),
    .busy(busy0),
`ifdef FETCH_PERF_EN
    .fetch_count(fetch_count0), .stall_count(stall_count0),
`endif
    .done(done0)
  );

  fetch_sequencer #(.N(32), .M(4), .START_PC(0)) u1 (
    .clk(clk), .rst(rst), .start(start1),
    .imem_addr(imem_addr1), .imem_instr(imem_instr1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_instr(out_instr1), .out_pc(out_pc1),
    .redirect(redirect1), .redirect_pc(redirect_pc1),
    .busy(busy1),
`ifdef FETCH_PERF_EN
    .fetch_count(fetch_count1), .stall_count(stall_count1),
`endif
    .done(done1)
  );

  assign imem_instr0 = (imem_addr0 < 32'd256) ? mem0[imem_addr0[7:0]] : 32'hDEAD_BEEF;
  assign imem_instr1 = (imem_addr1 < 32'd4) ? mem1[imem_addr1[1:0]] : 32'hFFFF_FFFF;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && (imem_addr1 > max_addr1)) max_addr1 <= imem_addr1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; scoreboard-checks any word accepted by u0 at this edge.
  task automatic tick();
    logic        acc;
    logic [31:0] p;
    logic [31:0] ins;
    exp_t        e;
    acc = out_valid0 && out_ready0 && !redirect0;
    p   = out_pc0;
    ins = out_instr0;
    @(posedge clk);
    #1;
    cyc++;
    if (acc) begin
      if (first_acc < 0) first_acc = cyc;
      last_acc = cyc;
      if (sbq.size() == 0) begin
        chk("sb_unexpected_pc", {32'd0, p}, 64'hFFFF_FFFF);
      end else begin
        e = sbq.pop_front();
        chk("sb_pc", {32'd0, p}, {32'd0, e.pc});
        chk("sb_instr", {32'd0, ins}, {32'd0, e.instr});
      end
    end
  endtask

  task automatic push_range(input int a, input int b);
    exp_t e;
    for (int i = a; i <= b; i++) begin
      e.pc    = i;
      e.instr = mem0[i];
      sbq.push_back(e);
    end
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while ((sbq.size() != 0) && (k < budget)) begin
      tick();
      k++;
    end
    chk("drain_left", sbq.size(), 64'd0);
  endtask

  task automatic wait_pc(input logic [31:0] t, input int budget);
    bit found;
    found = 1'b0;
    for (int k = 0; (k < budget) && !found; k++) begin
      tick();
      if (out_valid0 && (out_pc0 == t)) found = 1'b1;
    end
    chk("wait_pc_found", {63'd0, found}, 64'd1);
  endtask

  task automatic start_u0();
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem0[i] = 32'hA000_0000 | i;
    mem0[9] = 32'h0000_0000;
    for (int i = 0; i < 4; i++) mem1[i] = 32'hB000_0000 | (i + 1);
    rst = 1'b1;
    start0 = 1'b0; out_ready0 = 1'b1; redirect0 = 1'b0; redirect_pc0 = 32'd0;
    start1 = 1'b0; out_ready1 = 1'b1; redirect1 = 1'b0; redirect_pc1 = 32'd0;
    max_addr1 = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {63'd0, out_valid0}, 64'd0);
    chk("rst_busy", {63'd0, busy0}, 64'd0);
    chk("rst_done", {63'd0, done0}, 64'd0);
    chk("rst_out_pc", {32'd0, out_pc0}, 64'd0);
    chk("rst_out_instr", {32'd0, out_instr0}, 64'd0);
    chk("rst_imem_addr", {32'd0, imem_addr0}, 64'd0);
    rst = 1'b0;
    tick();

    // Straight-line program 0..9 terminated by the zero word.
    push_range(0, 9);
    first_acc = -1;
    start_u0();
    chk("run_busy", {63'd0, busy0}, 64'd1);
    drain(30);
    chk("run_no_bubble", last_acc - first_acc, 64'd9);
    chk("run_done", {63'd0, done0}, 64'd1);
    chk("run_busy_end", {63'd0, busy0}, 64'd0);
    chk("run_valid_end", {63'd0, out_valid0}, 64'd0);
    chk("run_pc_frozen", {32'd0, imem_addr0}, 64'd9);
    tick();
    chk("run_pc_frozen2", {32'd0, imem_addr0}, 64'd9);

    // Backpressure while word 2 is presented.
    push_range(0, 9);
    start_u0();
    wait_pc(32'd2, 10);
    out_ready0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_valid", {63'd0, out_valid0}, 64'd1);
      chk("bp_pc", {32'd0, out_pc0}, 64'd2);
      chk("bp_instr", {32'd0, out_instr0}, {32'd0, mem0[2]});
      chk("bp_addr", {32'd0, imem_addr0}, 64'd3);
    end
    out_ready0 = 1'b1;
    tick();
    chk("bp_release_valid", {63'd0, out_valid0}, 64'd1);
    chk("bp_release_pc", {32'd0, out_pc0}, 64'd3);
    drain(20);

    // Redirect from word 4 to word 6: word 4 flushed, word 5 never shown.
    push_range(0, 3);
    start_u0();
    wait_pc(32'd4, 10);
    redirect0 = 1'b1;
    redirect_pc0 = 32'd6;
    tick();
    redirect0 = 1'b0;
    chk("rd_bubble_valid", {63'd0, out_valid0}, 64'd0);
    push_range(6, 9);
    tick();
    chk("rd_target_valid", {63'd0, out_valid0}, 64'd1);
    chk("rd_target_pc", {32'd0, out_pc0}, 64'd6);
    chk("rd_target_instr", {32'd0, out_instr0}, {32'd0, mem0[6]});
    drain(20);

    // Redirect while stalled on word 2, back to word 0.
    push_range(0, 1);
    start_u0();
    wait_pc(32'd2, 10);
    out_ready0 = 1'b0;
    tick();
    tick();
    redirect0 = 1'b1;
    redirect_pc0 = 32'd0;
    tick();
    redirect0 = 1'b0;
    out_ready0 = 1'b1;
    chk("rds_dropped", {63'd0, out_valid0}, 64'd0);
    chk("rds_addr", {32'd0, imem_addr0}, 64'd0);
    push_range(0, 9);
    tick();
    chk("rds_restart_valid", {63'd0, out_valid0}, 64'd1);
    chk("rds_restart_pc", {32'd0, out_pc0}, 64'd0);
    drain(20);

    // Depth-4 instance: end of memory without a terminator word.
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("m4_valid", {63'd0, out_valid1}, 64'd1);
      chk("m4_pc", {32'd0, out_pc1}, i);
      chk("m4_instr", {32'd0, out_instr1}, {32'd0, mem1[i]});
      chk("m4_done", {63'd0, done1}, (i == 3) ? 64'd1 : 64'd0);
      tick();
    end
    chk("m4_end_valid", {63'd0, out_valid1}, 64'd0);
    chk("m4_end_done", {63'd0, done1}, 64'd1);
    chk("m4_end_addr", {32'd0, imem_addr1}, 64'd3);
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    chk("m4_restart_pc", {32'd0, out_pc1}, 64'd0);
    redirect1 = 1'b1;
    redirect_pc1 = 32'd4;
    tick();
    redirect1 = 1'b0;
    chk("m4_oob_valid", {63'd0, out_valid1}, 64'd0);
    chk("m4_oob_done", {63'd0, done1}, 64'd1);
    chk("m4_oob_busy", {63'd0, busy1}, 64'd0);
    tick();
    chk("m4_oob_valid2", {63'd0, out_valid1}, 64'd0);
    chk("m4_max_addr", {63'd0, (max_addr1 <= 32'd3)}, 64'd1);

    // Asynchronous reset between edges while stalled.
    push_range(0, 1);
    start_u0();
    wait_pc(32'd2, 10);
    out_ready0 = 1'b0;
    tick();
    tick();
    chk("ar_pre_busy", {63'd0, busy0}, 64'd1);
    #3;
    rst = 1'b1;
    #1;
    chk("ar_valid", {63'd0, out_valid0}, 64'd0);
    chk("ar_busy", {63'd0, busy0}, 64'd0);
    chk("ar_done", {63'd0, done0}, 64'd0);
    chk("ar_pc", {32'd0, imem_addr0}, 64'd0);
    rst = 1'b0;
    out_ready0 = 1'b1;
    push_range(0, 9);
    start_u0();
    drain(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
